tlb_request_sequencer: RTL

// - Upstream front-end of the speculative TLB. Accepts virtual-address translation requests

---
 rtl/tlb_request_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/tlb_request_sequencer.sv
// tlb_request_sequencer
// Front-end of the speculative TLB. Translation requests arrive on a
// valid/ready port and are queued in an in-order FIFO. Each one is then issued
// to the TLB on a level handshake (TRANS_RQST/SPEC_TLB_RQST, held until
// DONE_TRANS). Its result comes back on a valid/ready response port.
// Hit/miss/timeout statistics are kept in saturating counters.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   REQ_VALID/READY/VADDR/SPEC   request port (READY = FIFO not full, registered)
//   RSP_VALID/READY/PADDR/TLB_HIT/SPEC_HIT/ERR   response port
//   TRANS_RQST, SPEC_TLB_RQST, VIRT_ADDR_LOOKUP  outputs to the TLB
//   DONE_TRANS, TLB_HIT, SPEC_HIT, PHY_ADDR_TRANS inputs from the TLB
//   HIT_CNT, MISS_CNT, TIMEOUT_CNT               saturating statistics
module tlb_request_sequencer #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [7:0]       REQ_VADDR,
    input  logic             REQ_SPEC,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [7:0]       RSP_PADDR,
    output logic             RSP_TLB_HIT,
    output logic             RSP_SPEC_HIT,
    output logic             RSP_ERR,
    output logic             TRANS_RQST,
    output logic             SPEC_TLB_RQST,
    output logic [7:0]       VIRT_ADDR_LOOKUP,
    input  logic             DONE_TRANS,
    input  logic             TLB_HIT,
    input  logic             SPEC_HIT,
    input  logic [7:0]       PHY_ADDR_TRANS,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [CNT_W-1:0] MISS_CNT,
    output logic [CNT_W-1:0] TIMEOUT_CNT
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_FW = $clog2(DEPTH + 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    logic [8:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;
    logic req_ready_q, req_ready_d;
    state_t state_q, state_d;
    logic [7:0] vaddr_q, vaddr_d;
    logic spec_q, spec_d;
    logic trans_rqst_q, trans_rqst_d, spec_rqst_q, spec_rqst_d;
    logic [15:0] timer_q, timer_d;
    logic rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
    logic rsp_spec_hit_q, rsp_spec_hit_d, rsp_err_q, rsp_err_d;
    logic [7:0] rsp_paddr_q, rsp_paddr_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, to_cnt_q, to_cnt_d;
    logic push, pop;
    logic [8:0] head;

    assign push = REQ_VALID & req_ready_q;
    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        vaddr_d        = vaddr_q;
        spec_d         = spec_q;
        trans_rqst_d   = trans_rqst_q;
        spec_rqst_d    = spec_rqst_q;
        timer_d        = timer_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_paddr_d    = rsp_paddr_q;
        rsp_hit_d      = rsp_hit_q;
        rsp_spec_hit_d = rsp_spec_hit_q;
        rsp_err_d      = rsp_err_q;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        to_cnt_d       = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // First ISSUE cycle only launches the registered request; the
                // TLB is known idle here because DRAIN saw DONE_TRANS low.
                if (!trans_rqst_q) begin
                    trans_rqst_d = 1'b1;
                    spec_rqst_d  = spec_q;
                    timer_d      = '0;
                end else if (DONE_TRANS) begin
                    rsp_paddr_d    = PHY_ADDR_TRANS;
                    rsp_hit_d      = TLB_HIT;
                    rsp_spec_hit_d = SPEC_HIT;
                    rsp_err_d      = 1'b0;
                    if (TLB_HIT) hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
                    else miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
                    trans_rqst_d = 1'b0;
                    spec_rqst_d  = 1'b0;
                    state_d      = DRAIN;
                end else if (timer_q == TO_LAST) begin
                    // Request has been high TIMEOUT_CYC cycles: abort.
                    rsp_paddr_d    = '0;
                    rsp_hit_d      = 1'b0;
                    rsp_spec_hit_d = 1'b0;
                    rsp_err_d      = 1'b1;
                    to_cnt_d       = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 1'b1;
                    trans_rqst_d   = 1'b0;
                    spec_rqst_d    = 1'b0;
                    state_d        = DRAIN;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DRAIN: begin
                if (!DONE_TRANS) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            vaddr_d = head[7:0];
            spec_d  = head[8];
        end
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + {{(CNT_FW-1){1'b0}}, push} - {{(CNT_FW-1){1'b0}}, pop};
        req_ready_d = (count_d < CNT_FW'(DEPTH));
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {REQ_SPEC, REQ_VADDR};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            req_ready_q    <= 1'b0;
            vaddr_q        <= '0;
            spec_q         <= 1'b0;
            trans_rqst_q   <= 1'b0;
            spec_rqst_q    <= 1'b0;
            timer_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_paddr_q    <= '0;
            rsp_hit_q      <= 1'b0;
            rsp_spec_hit_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            to_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            req_ready_q    <= req_ready_d;
            vaddr_q        <= vaddr_d;
            spec_q         <= spec_d;
            trans_rqst_q   <= trans_rqst_d;
            spec_rqst_q    <= spec_rqst_d;
            timer_q        <= timer_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_paddr_q    <= rsp_paddr_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_spec_hit_q <= rsp_spec_hit_d;
            rsp_err_q      <= rsp_err_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign REQ_READY        = req_ready_q;
    assign RSP_VALID        = rsp_valid_q;
    assign RSP_PADDR        = rsp_paddr_q;
    assign RSP_TLB_HIT      = rsp_hit_q;
    assign RSP_SPEC_HIT     = rsp_spec_hit_q;
    assign RSP_ERR          = rsp_err_q;
    assign TRANS_RQST       = trans_rqst_q;
    assign SPEC_TLB_RQST    = spec_rqst_q;
    assign VIRT_ADDR_LOOKUP = vaddr_q;
    assign HIT_CNT          = hit_cnt_q;
    assign MISS_CNT         = miss_cnt_q;
    assign TIMEOUT_CNT      = to_cnt_q;
endmodule
